rggen_register_bus_splitter: RTL and testbench
==============================================

RGGEN_REGISTER_BUS_SPLITTER -- requirements
Module: rggen_register_bus_splitter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, host/register address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width in bits; a multiple of 8.
REQ-003 SHALL have parameter REGISTERS, default 4, number of register channels; range 1..64.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-state cycles; 0 disables the timeout.
REQ-005 SHALL have port clk  input  1  sole clock; all logic samples on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert and active-low.
REQ-007 SHALL have port host_request  input  1  access request, held until host_ready.
REQ-008 SHALL have port host_address  input  ADDRESS_WIDTH  access address.
REQ-009 SHALL have port host_direction  input  rggen_direction  RGGEN_READ=0, RGGEN_WRITE=1.
REQ-010 SHALL have port host_write_data  input  DATA_WIDTH  write data.
REQ-011 SHALL have port host_write_strobe  input  DATA_WIDTH/8  byte enables.
REQ-012 SHALL have port host_ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port host_read_data  output  DATA_WIDTH  read data, valid with host_ready.
REQ-014 SHALL have port host_status  output  rggen_status  OKAY=0, EXOKAY=1, SLAVE_ERROR=2, DECODE_ERROR=3.
REQ-015 SHALL have port reg_request  output  REGISTERS  per-channel request.
REQ-016 SHALL have ports reg_address, reg_direction, reg_write_data and reg_write_strobe, all outputs with host widths, broadcast to every channel.
REQ-017 SHALL have ports reg_select, reg_ready (inputs, REGISTERS wide), reg_read_data (input, REGISTERS*DATA_WIDTH, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]) and reg_status (input, REGISTERS*2).

Function
REQ-018 SHALL implement FSM IDLE -> ACCESS -> RESPONSE -> IDLE; one access outstanding at most.
REQ-019 In IDLE, a sampled host_request SHALL capture address, direction, write data and strobe into internal registers, clear the timeout counter and enter ACCESS.
REQ-020 In ACCESS, reg_request SHALL be all-ones, with reg_address, reg_direction, reg_write_data and reg_write_strobe driven from the captured values; reg_request SHALL be all-zeros in IDLE and RESPONSE.
REQ-021 In ACCESS, zero reg_select bits SHALL end the access with DECODE_ERROR and read data 0.
REQ-022 In ACCESS, more than one reg_select bit SHALL end the access with SLAVE_ERROR and read data 0.
REQ-023 In ACCESS, exactly one selected channel i with reg_ready[i]=1 SHALL capture reg_read_data and reg_status of channel i; ready on unselected channels SHALL be ignored.
REQ-024 For completed writes, read data SHALL be forced to 0 regardless of the channel's value.
REQ-025 For each ACCESS cycle without completion, the counter SHALL increment.
REQ-026 With TIMEOUT_CYCLES>0, counter == TIMEOUT_CYCLES-1 without completion SHALL end the access with SLAVE_ERROR and read data 0.
REQ-027 The counter width SHALL be max(1, $clog2(TIMEOUT_CYCLES+1)), with no wrap inside one access.
REQ-028 RESPONSE SHALL last exactly one cycle with host_ready=1 and the captured read data and status, then return to IDLE.
REQ-029 host_read_data SHALL be 0 whenever host_ready=0.
REQ-030 Minimum latency SHALL be 2 cycles from the request-sampling edge to host_ready high.
REQ-031 A request held high after host_ready SHALL be accepted as a new access in the following IDLE cycle.
REQ-032 The captured address and data SHALL be stable for the whole ACCESS phase, independent of changes on the host inputs.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, counter 0, host_ready 0, host_read_data 0, host_status OKAY, reg_request 0, and captured address, data and strobe 0.
REQ-034 A reset mid-ACCESS SHALL abort the access silently: no host_ready pulse, and reg_request drops asynchronously.

Structure
REQ-035 The rggen_direction and rggen_status enums SHALL be taken from rggen_rtl_pkg; no new typedefs SHALL be added.
REQ-036 A sub-module rggen_register_response_mux SHALL be used: combinational one-hot select check (none, one, multi) plus read_data/status/ready mux.
REQ-037 The FSM, counter and capture registers SHALL reside in the top module.

Verification
REQ-038 Read of channel 2 (select=4'b0100, ready after 3 ACCESS cycles, data 32'hDEAD_BEEF, OKAY) -> host_ready 5 cycles after request, read_data DEAD_BEEF, status OKAY.
REQ-039 Write of 32'h1234_5678 with strobe 4'b0011 to channel 0 -> reg_write_data and reg_write_strobe match for every ACCESS cycle, host_read_data 0, status OKAY.
REQ-040 Request with reg_select=0 -> host_ready 2 cycles after request, status DECODE_ERROR, reg_request high for exactly 1 cycle.
REQ-041 reg_select=4'b0101 with ready on both channels -> SLAVE_ERROR, read_data 0.
REQ-042 TIMEOUT_CYCLES=4 with the selected channel never ready -> ACCESS exactly 4 cycles, then SLAVE_ERROR; with TIMEOUT_CYCLES=0 and no ready for 1000 cycles -> no host_ready.
REQ-043 rst_n low during ACCESS cycle 2 -> reg_request 0 immediately, no host_ready; first access after reset completes normally.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared RgGen bus types.
//   rggen_direction : access direction (READ=0, WRITE=1)
//   rggen_status    : response status (OKAY, EXOKAY, SLAVE_ERROR, DECODE_ERROR)
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'd0,
        RGGEN_EXOKAY       = 2'd1,
        RGGEN_SLAVE_ERROR  = 2'd2,
        RGGEN_DECODE_ERROR = 2'd3
    } rggen_status;

endpackage

// File: rtl/rggen_register_response_mux.sv
// Combinational response selection for the register bus splitter.
// Classifies the per-channel select vector (none / exactly one / several) and
// muxes ready, read data and status of the selected channel.
//   select, ready        : per-channel select and ready flags
//   read_data, status    : packed per-channel responses, channel i at slice i
//   select_none/multi    : no channel selected / more than one selected
//   selected_*           : ready, read data and status of the selected channel
//                          (meaningful only when exactly one is selected)
module rggen_register_response_mux
    import rggen_rtl_pkg::*;
#(
    parameter int REGISTERS  = 4,
    parameter int DATA_WIDTH = 32
)(
    input  logic [REGISTERS-1:0]            select,
    input  logic [REGISTERS-1:0]            ready,
    input  logic [REGISTERS*DATA_WIDTH-1:0] read_data,
    input  logic [REGISTERS*2-1:0]          status,
    output logic                            select_none,
    output logic                            select_multi,
    output logic                            selected_ready,
    output logic [DATA_WIDTH-1:0]           selected_read_data,
    output rggen_status                     selected_status
);

    logic [1:0] status_or;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign select_none  = ~|select;
    assign select_multi = |(select & (select - REGISTERS'(1)));

    // AND-OR mux: with a one-hot select only the chosen channel contributes.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // through the block can leave a value held and infer a latch.
        selected_ready     = 1'b0;
        selected_read_data = '0;
        status_or          = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (select[i]) begin
                selected_ready     = selected_ready | ready[i];
                selected_read_data = selected_read_data | read_data[i*DATA_WIDTH +: DATA_WIDTH];
                status_or          = status_or | status[2*i +: 2];
            end
        end
    end

    assign selected_status = rggen_status'(status_or);

endmodule

// File: rtl/rggen_register_bus_splitter.sv
// Splits one host register access across REGISTERS register channels.
// A host request is captured in IDLE, broadcast to every channel during
// ACCESS, and answered with a one-cycle host_ready pulse in RESPONSE.
//   clk, rst_n            : clock, asynchronous active-low reset
//   host_*                : host side request / response
//   reg_request           : per-channel request, all-ones during ACCESS
//   reg_address/direction/write_data/write_strobe : captured access, broadcast
//   reg_select/ready/read_data/status             : per-channel responses
module rggen_register_bus_splitter
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTERS      = 4,
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            host_request,
    input  logic [ADDRESS_WIDTH-1:0]        host_address,
    input  rggen_direction                  host_direction,
    input  logic [DATA_WIDTH-1:0]           host_write_data,
    input  logic [DATA_WIDTH/8-1:0]         host_write_strobe,
    output logic                            host_ready,
    output logic [DATA_WIDTH-1:0]           host_read_data,
    output rggen_status                     host_status,
    output logic [REGISTERS-1:0]            reg_request,
    output logic [ADDRESS_WIDTH-1:0]        reg_address,
    output rggen_direction                  reg_direction,
    output logic [DATA_WIDTH-1:0]           reg_write_data,
    output logic [DATA_WIDTH/8-1:0]         reg_write_strobe,
    input  logic [REGISTERS-1:0]            reg_select,
    input  logic [REGISTERS-1:0]            reg_ready,
    input  logic [REGISTERS*DATA_WIDTH-1:0] reg_read_data,
    input  logic [REGISTERS*2-1:0]          reg_status
);

    localparam int COUNTER_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TIMEOUT_LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [1:0] STATE_IDLE     = 2'd0;
    localparam logic [1:0] STATE_ACCESS   = 2'd1;
    localparam logic [1:0] STATE_RESPONSE = 2'd2;

    logic [1:0]               state;
    logic [COUNTER_WIDTH-1:0] counter;
    logic [ADDRESS_WIDTH-1:0] address;
    rggen_direction           direction;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [DATA_WIDTH/8-1:0]  write_strobe;
    logic                     response_ready;
    logic [DATA_WIDTH-1:0]    response_data;
    rggen_status              response_status;

    logic                     select_none;
    logic                     select_multi;
    logic                     selected_ready;
    logic [DATA_WIDTH-1:0]    selected_read_data;
    rggen_status              selected_status;

    logic                     timeout_hit;
    logic                     complete;
    logic [DATA_WIDTH-1:0]    complete_data;
    rggen_status              complete_status;

    rggen_register_response_mux #(
        .REGISTERS  (REGISTERS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_response_mux (
        .select             (reg_select),
        .ready              (reg_ready),
        .read_data          (reg_read_data),
        .status             (reg_status),
        .select_none        (select_none),
        .select_multi       (select_multi),
        .selected_ready     (selected_ready),
        .selected_read_data (selected_read_data),
        .selected_status    (selected_status)
    );

    // A zero timeout means "wait forever"; the counter then only saturates.
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
        assign timeout_hit = (counter == COUNTER_WIDTH'(TIMEOUT_LAST));
    end else begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end

    // Completion priority: decode error, multi-select, channel ready, timeout.
    always_comb begin
        complete        = 1'b0;
        complete_data   = '0;
        complete_status = RGGEN_OKAY;
        if (select_none) begin
            complete        = 1'b1;
            complete_status = RGGEN_DECODE_ERROR;
        end else if (select_multi) begin
            complete        = 1'b1;
            complete_status = RGGEN_SLAVE_ERROR;
        end else if (selected_ready) begin
            complete        = 1'b1;
            complete_status = selected_status;
            complete_data   = (direction == RGGEN_WRITE) ? '0 : selected_read_data;
        end else if (timeout_hit) begin
            complete        = 1'b1;
            complete_status = RGGEN_SLAVE_ERROR;
        end
    end

    // NOTE: state and capture registers use non-blocking assignments so every
    // flop samples pre-edge values; the async reset clears them all at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= STATE_IDLE;
            counter         <= '0;
            address         <= '0;
            direction       <= RGGEN_READ;
            write_data      <= '0;
            write_strobe    <= '0;
            response_ready  <= 1'b0;
            response_data   <= '0;
            response_status <= RGGEN_OKAY;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (host_request) begin
                        address      <= host_address;
                        direction    <= host_direction;
                        write_data   <= host_write_data;
                        write_strobe <= host_write_strobe;
                        counter      <= '0;
                        state        <= STATE_ACCESS;
                    end
                end
                STATE_ACCESS: begin
                    if (complete) begin
                        response_ready  <= 1'b1;
                        response_data   <= complete_data;
                        response_status <= complete_status;
                        state           <= STATE_RESPONSE;
                    end else if (!(&counter)) begin
                        counter <= counter + COUNTER_WIDTH'(1);
                    end
                end
                STATE_RESPONSE: begin
                    // Clearing here keeps host_read_data at zero outside the pulse.
                    response_ready  <= 1'b0;
                    response_data   <= '0;
                    response_status <= RGGEN_OKAY;
                    state           <= STATE_IDLE;
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

    // reg_request decodes straight from the state flop so reset drops it at once.
    assign reg_request      = {REGISTERS{state == STATE_ACCESS}};
    assign reg_address      = address;
    assign reg_direction    = direction;
    assign reg_write_data   = write_data;
    assign reg_write_strobe = write_strobe;

    assign host_ready       = response_ready;
    assign host_read_data   = response_data;
    assign host_status      = response_status;

endmodule

// File: tb/tb_rggen_register_bus_splitter.sv
// Bench for rggen_register_bus_splitter: randomized transactions checked each
// cycle against a transaction-level model, plus directed literal scenarios.
module tb_rggen_register_bus_splitter;
    import rggen_rtl_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int TO = 4;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main DUT
    logic              host_request;
    logic [AW-1:0]     host_address;
    rggen_direction    host_direction;
    logic [DW-1:0]     host_write_data;
    logic [SW-1:0]     host_write_strobe;
    logic              host_ready;
    logic [DW-1:0]     host_read_data;
    rggen_status       host_status;
    logic [NR-1:0]     reg_request;
    logic [AW-1:0]     reg_address;
    rggen_direction    reg_direction;
    logic [DW-1:0]     reg_write_data;
    logic [SW-1:0]     reg_write_strobe;
    logic [NR-1:0]     reg_select;
    logic [NR-1:0]     reg_ready;
    logic [NR*DW-1:0]  reg_read_data;
    logic [NR*2-1:0]   reg_status;

    // second DUT: timeout disabled, one channel that never answers
    logic              z_host_ready;
    logic [DW-1:0]     z_host_read_data;
    rggen_status       z_host_status;
    logic [0:0]        z_reg_request;
    logic [AW-1:0]     z_reg_address;
    rggen_direction    z_reg_direction;
    logic [DW-1:0]     z_reg_write_data;
    logic [SW-1:0]     z_reg_write_strobe;
    logic [0:0]        z_select    = 1'b1;
    logic [0:0]        z_ready     = 1'b0;
    logic [DW-1:0]     z_read_data = 32'hFFFF_FFFF;
    logic [1:0]        z_status    = 2'd0;

    rggen_register_bus_splitter #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .REGISTERS(NR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .host_request(host_request), .host_address(host_address),
        .host_direction(host_direction), .host_write_data(host_write_data),
        .host_write_strobe(host_write_strobe), .host_ready(host_ready),
        .host_read_data(host_read_data), .host_status(host_status),
        .reg_request(reg_request), .reg_address(reg_address),
        .reg_direction(reg_direction), .reg_write_data(reg_write_data),
        .reg_write_strobe(reg_write_strobe), .reg_select(reg_select),
        .reg_ready(reg_ready), .reg_read_data(reg_read_data), .reg_status(reg_status)
    );

    rggen_register_bus_splitter #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .REGISTERS(1), .TIMEOUT_CYCLES(0)
    ) dut_no_timeout (
        .clk(clk), .rst_n(rst_n),
        .host_request(host_request), .host_address(host_address),
        .host_direction(host_direction), .host_write_data(host_write_data),
        .host_write_strobe(host_write_strobe), .host_ready(z_host_ready),
        .host_read_data(z_host_read_data), .host_status(z_host_status),
        .reg_request(z_reg_request), .reg_address(z_reg_address),
        .reg_direction(z_reg_direction), .reg_write_data(z_reg_write_data),
        .reg_write_strobe(z_reg_write_strobe), .reg_select(z_select),
        .reg_ready(z_ready), .reg_read_data(z_read_data), .reg_status(z_status)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    typedef struct {
        logic [NR-1:0]  select;
        int             delay;     // ACCESS cycles without ready before the selected channel answers
        logic [DW-1:0]  data;
        logic [1:0]     status;
        rggen_direction dir;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [SW-1:0]  strobe;
    } plan_t;

    // Transaction-level model: how many ACCESS cycles and what the host sees.
    function automatic void model(input plan_t p, output int cycles,
                                  output logic [DW-1:0] data, output logic [1:0] status);
        if ($countones(p.select) == 0) begin
            cycles = 1; data = '0; status = 2'd3;
        end else if ($countones(p.select) > 1) begin
            cycles = 1; data = '0; status = 2'd2;
        end else if (p.delay + 1 <= TO) begin
            cycles = p.delay + 1;
            data   = (p.dir == RGGEN_WRITE) ? '0 : p.data;
            status = p.status;
        end else begin
            cycles = TO; data = '0; status = 2'd2;
        end
    endfunction

    // expectations consumed by the compare process
    bit             exp_en = 1'b0;
    bit             exp_access = 1'b0;
    bit             exp_ready = 1'b0;
    logic [DW-1:0]  exp_data = '0;
    logic [1:0]     exp_status = '0;
    logic [AW-1:0]  exp_address = '0;
    rggen_direction exp_dir = RGGEN_READ;
    logic [DW-1:0]  exp_wdata = '0;
    logic [SW-1:0]  exp_strobe = '0;

    int             cyc = 0;
    int             p0_cyc = 0;
    int             ready_cyc = 0;
    int             req_high_count = 0;
    logic [DW-1:0]  seen_data = '0;
    logic [1:0]     seen_status = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (exp_en) begin
            check("reg_request", 64'(reg_request), 64'({NR{exp_access}}));
            check("host_ready", 64'(host_ready), 64'(exp_ready));
            check("host_read_data", 64'(host_read_data), 64'(exp_data));
            if (exp_ready)
                check("host_status", 64'(host_status), 64'(exp_status));
            if (exp_access) begin
                check("reg_address", 64'(reg_address), 64'(exp_address));
                check("reg_direction", 64'(reg_direction), 64'(exp_dir));
                check("reg_write_data", 64'(reg_write_data), 64'(exp_wdata));
                check("reg_write_strobe", 64'(reg_write_strobe), 64'(exp_strobe));
            end
        end
        if (host_ready) begin
            ready_cyc   = cyc + 1;
            seen_data   = host_read_data;
            seen_status = host_status;
        end
        if (|reg_request) req_high_count++;
    end

    // no-timeout DUT monitor
    int             z_ready_pulses = 0;
    int             z_start_cyc = -1;
    logic [AW-1:0]  z_addr0;
    logic [DW-1:0]  z_wdata0;
    logic [SW-1:0]  z_strobe0;
    rggen_direction z_dir0;

    always @(negedge clk) begin
        if (z_host_ready) z_ready_pulses++;
        if (z_reg_request[0] && z_start_cyc < 0) begin
            z_start_cyc = cyc;
            z_addr0     = z_reg_address;
            z_wdata0    = z_reg_write_data;
            z_strobe0   = z_reg_write_strobe;
            z_dir0      = z_reg_direction;
        end
    end

    task automatic drive_reg(input plan_t p, input int k);
        int idx;
        idx = 0;
        for (int i = 0; i < NR; i++) reg_read_data[i*DW +: DW] = $urandom;
        reg_status = (2*NR)'($urandom);
        reg_ready  = NR'($urandom);
        reg_select = p.select;
        if ($countones(p.select) == 1) begin
            for (int i = 0; i < NR; i++) if (p.select[i]) idx = i;
            reg_ready[idx] = (k == p.delay + 1);
            if (k == p.delay + 1) begin
                reg_read_data[idx*DW +: DW] = p.data;
                reg_status[2*idx +: 2]      = p.status;
            end
        end else if ($countones(p.select) > 1) begin
            reg_ready = reg_ready | p.select;
        end
    endtask

    task automatic idle_cycle();
        host_request = 1'b0;
        exp_access = 1'b0; exp_ready = 1'b0; exp_data = '0;
        @(posedge clk); #1;
    endtask

    // Entered just after an edge with the DUT in IDLE; returns just after the
    // edge that ends RESPONSE.
    task automatic run_txn(input plan_t p, input bit hold_after);
        int            n;
        logic [DW-1:0] edata;
        logic [1:0]    estatus;
        model(p, n, edata, estatus);
        host_request      = 1'b1;
        host_address      = p.addr;
        host_direction    = p.dir;
        host_write_data   = p.wdata;
        host_write_strobe = p.strobe;
        reg_select = NR'($urandom);
        reg_ready  = NR'($urandom);
        exp_access = 1'b0; exp_ready = 1'b0; exp_data = '0;
        req_high_count = 0;
        @(posedge clk); #1;
        p0_cyc = cyc;
        exp_address = p.addr; exp_dir = p.dir; exp_wdata = p.wdata; exp_strobe = p.strobe;
        for (int k = 1; k <= n; k++) begin
            host_address      = AW'($urandom);
            host_direction    = rggen_direction'(1'($urandom));
            host_write_data   = $urandom;
            host_write_strobe = SW'($urandom);
            drive_reg(p, k);
            exp_access = 1'b1; exp_ready = 1'b0; exp_data = '0;
            @(posedge clk); #1;
        end
        host_request = hold_after;
        reg_ready    = NR'($urandom);
        exp_access = 1'b0; exp_ready = 1'b1; exp_data = edata; exp_status = estatus;
        @(posedge clk); #1;
        exp_ready = 1'b0; exp_data = '0;
    endtask

    function automatic plan_t rand_plan();
        plan_t p;
        int    r;
        r = $urandom_range(0, 99);
        if (r < 70) p.select = NR'(1) << $urandom_range(0, NR-1);
        else if (r < 85) p.select = '0;
        else begin
            do p.select = NR'($urandom); while ($countones(p.select) < 2);
        end
        p.delay  = $urandom_range(0, 5);
        p.data   = $urandom;
        p.status = 2'($urandom);
        p.dir    = rggen_direction'(1'($urandom));
        p.addr   = AW'($urandom);
        p.wdata  = $urandom;
        p.strobe = SW'($urandom);
        return p;
    endfunction

    function automatic plan_t make_plan(input logic [NR-1:0] sel, input int delay,
                                        input logic [DW-1:0] data, input rggen_direction dir,
                                        input logic [DW-1:0] wdata, input logic [SW-1:0] strobe);
        plan_t p;
        p.select = sel; p.delay = delay; p.data = data; p.status = 2'd0;
        p.dir = dir; p.addr = 16'h0040; p.wdata = wdata; p.strobe = strobe;
        return p;
    endfunction

    initial begin
        plan_t p;
        int    n_pin;
        logic [DW-1:0] d_pin;
        logic [1:0]    s_pin;

        rst_n = 1'b0;
        host_request = 1'b0; host_address = '0; host_direction = RGGEN_READ;
        host_write_data = '0; host_write_strobe = '0;
        reg_select = '0; reg_ready = '0; reg_read_data = '0; reg_status = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset host_ready", 64'(host_ready), 64'd0);
        check("reset host_read_data", 64'(host_read_data), 64'd0);
        check("reset host_status", 64'(host_status), 64'd0);
        check("reset reg_request", 64'(reg_request), 64'd0);
        check("reset reg_address", 64'(reg_address), 64'd0);
        check("reset reg_write_data", 64'(reg_write_data), 64'd0);
        check("reset reg_write_strobe", 64'(reg_write_strobe), 64'd0);
        rst_n = 1'b1;
        exp_en = 1'b1;
        idle_cycle();

        // model pins: hand-computed outcomes
        model(make_plan(4'b0100, 3, 32'hDEAD_BEEF, RGGEN_READ, '0, '0), n_pin, d_pin, s_pin);
        check("model read cycles", 64'(n_pin), 64'd4);
        check("model read data", 64'(d_pin), 64'hDEAD_BEEF);
        model(make_plan(4'b0010, 9, 32'h1, RGGEN_READ, '0, '0), n_pin, d_pin, s_pin);
        check("model timeout cycles", 64'(n_pin), 64'd4);
        check("model timeout status", 64'(s_pin), 64'd2);

        // read of channel 2, ready after 3 ACCESS cycles
        run_txn(make_plan(4'b0100, 3, 32'hDEAD_BEEF, RGGEN_READ, 32'h0, 4'h0), 1'b0);
        check("read latency", 64'(ready_cyc - p0_cyc), 64'd5);
        check("read data", 64'(seen_data), 64'hDEAD_BEEF);
        check("read status", 64'(seen_status), 64'd0);
        idle_cycle();

        // write to channel 0
        run_txn(make_plan(4'b0001, 2, 32'hCAFE_F00D, RGGEN_WRITE, 32'h1234_5678, 4'b0011), 1'b0);
        check("write read_data", 64'(seen_data), 64'd0);
        check("write status", 64'(seen_status), 64'd0);
        idle_cycle();

        // no channel selected
        run_txn(make_plan(4'b0000, 0, 32'h5555_5555, RGGEN_READ, 32'h0, 4'h0), 1'b0);
        check("decode latency", 64'(ready_cyc - p0_cyc), 64'd2);
        check("decode status", 64'(seen_status), 64'd3);
        check("decode reg_request cycles", 64'(req_high_count), 64'd1);
        idle_cycle();

        // two channels selected, both ready
        run_txn(make_plan(4'b0101, 0, 32'h7777_7777, RGGEN_READ, 32'h0, 4'h0), 1'b0);
        check("multi status", 64'(seen_status), 64'd2);
        check("multi read_data", 64'(seen_data), 64'd0);
        idle_cycle();

        // selected channel never ready
        run_txn(make_plan(4'b1000, 100, 32'h9999_9999, RGGEN_READ, 32'h0, 4'h0), 1'b0);
        check("timeout access cycles", 64'(req_high_count), 64'd4);
        check("timeout status", 64'(seen_status), 64'd2);
        check("timeout read_data", 64'(seen_data), 64'd0);

        // randomized traffic, including back-to-back requests
        for (int t = 0; t < 200; t++) begin
            bit hold;
            hold = 1'($urandom);
            run_txn(rand_plan(), hold);
            if (!hold) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) idle_cycle();
            end
        end

        // the timeout-free instance must still be waiting after 1000+ cycles
        for (int w = 0; w < 2000 && (z_start_cyc < 0 || cyc - z_start_cyc < 1000); w++) idle_cycle();
        check("no-timeout reg_request held", 64'(z_reg_request), 64'd1);
        check("no-timeout host_ready pulses", 64'(z_ready_pulses), 64'd0);
        check("no-timeout address stable", 64'(z_reg_address), 64'(z_addr0));
        check("no-timeout wdata stable", 64'(z_reg_write_data), 64'(z_wdata0));
        check("no-timeout strobe stable", 64'(z_reg_write_strobe), 64'(z_strobe0));
        check("no-timeout direction stable", 64'(z_reg_direction), 64'(z_dir0));
        check("no-timeout read_data idle", 64'(z_host_read_data), 64'd0);
        check("no-timeout status idle", 64'(z_host_status), 64'd0);

        // reset in the middle of ACCESS cycle 2
        p = make_plan(4'b0010, 100, 32'h0, RGGEN_READ, 32'hA5A5_A5A5, 4'hF);
        host_request = 1'b1; host_address = p.addr; host_direction = p.dir;
        host_write_data = p.wdata; host_write_strobe = p.strobe;
        exp_access = 1'b0; exp_ready = 1'b0; exp_data = '0;
        @(posedge clk); #1;
        exp_address = p.addr; exp_dir = p.dir; exp_wdata = p.wdata; exp_strobe = p.strobe;
        drive_reg(p, 1);
        exp_access = 1'b1;
        @(posedge clk); #1;
        drive_reg(p, 2);
        exp_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset drops reg_request", 64'(reg_request), 64'd0);
        check("reset host_ready", 64'(host_ready), 64'd0);
        check("reset drops no-timeout reg_request", 64'(z_reg_request), 64'd0);
        host_request = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            check("host_ready in reset", 64'(host_ready), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_access = 1'b0; exp_ready = 1'b0; exp_data = '0;
        exp_en = 1'b1;
        idle_cycle();
        idle_cycle();

        // first access after reset
        run_txn(make_plan(4'b0010, 1, 32'h0BAD_F00D, RGGEN_READ, 32'h0, 4'h0), 1'b0);
        check("post-reset latency", 64'(ready_cyc - p0_cyc), 64'd3);
        check("post-reset data", 64'(seen_data), 64'h0BAD_F00D);
        idle_cycle();
        idle_cycle();
        check("no-timeout host_ready pulses final", 64'(z_ready_pulses), 64'd0);

        exp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
